// File: rtl/frac_sad_accum.sv
// frac_sad_accum
// Accumulates per-line absolute-difference sums for NCAND fractional
// motion-vector candidates over LINES rows. It then scans the accumulators
// for the candidate with the smallest SAD and presents it with a
// valid/ready handshake.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - a diff line beat is present on diff_in
//   in_ready  - beat accepted when in_valid && in_ready at clk edge
//   diff_in   - NCAND candidates x 8 pixels x 8-bit abs diffs,
//               candidate k at [64k+63:64k], pixel p at [64k+8p+7:64k+8p]
//   flush     - synchronous abort of the current block
//   out_valid - best result present
//   out_ready - result consumed when out_valid && out_ready
//   best_idx  - winning candidate index (k = 5*v + h, 12 = full-pel)
//   best_sad  - SAD of the winning candidate
module frac_sad_accum #(
  parameter int LINES = 8,
  parameter int NCAND = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*NCAND-1:0]   diff_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            best_idx,
  output logic [13:0]           best_sad
);

  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   line_q, line_d;
  logic [4:0]      scan_idx_q, scan_idx_d;
  logic            cand_vld_q, cand_vld_d;
  logic [4:0]      cand_idx_q, cand_idx_d;
  logic [13:0]     cand_sad_q, cand_sad_d;
  logic [4:0]      best_idx_q, best_idx_d;
  logic [13:0]     best_sad_q, best_sad_d;
  logic [13:0]     acc_q [NCAND];
  logic [13:0]     acc_d [NCAND];
  logic [10:0]     beat_sum [NCAND];
  logic            accept;

  // in_ready is gated by rst_n so that no beat looks accepted while reset is held.
  assign in_ready  = (state_q == ST_ACCUM) && rst_n;
  assign out_valid = (state_q == ST_OUT);
  assign best_idx  = best_idx_q;
  assign best_sad  = best_sad_q;
  assign accept    = in_valid && in_ready;

  // Per-candidate sum of the 8 pixel diffs in the current beat (max 2040, 11 bits)
  always_comb begin
    for (int k = 0; k < NCAND; k++) begin
      beat_sum[k] = '0;
      for (int p = 0; p < 8; p++) begin
        beat_sum[k] = beat_sum[k] + 11'(diff_in[64*k + 8*p +: 8]);
      end
    end
  end

  // Next-state logic. The scan is a two-stage pipeline: one cycle reads an
  // accumulator into cand_*, and the next cycle compares it against the running
  // minimum. This keeps the 25:1 mux and the comparator in separate cycles, and
  // it is the reason OUT is reached 26 cycles after the final beat.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    scan_idx_d = scan_idx_q;
    cand_vld_d = 1'b0;
    cand_idx_d = cand_idx_q;
    cand_sad_d = cand_sad_q;
    best_idx_d = best_idx_q;
    best_sad_d = best_sad_q;
    for (int k = 0; k < NCAND; k++) acc_d[k] = acc_q[k];

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          for (int k = 0; k < NCAND; k++) acc_d[k] = acc_q[k] + 14'(beat_sum[k]);
          if (line_q == LW'(LINES - 1)) begin
            line_d  = '0;
            state_d = ST_SCAN;
          end else begin
            line_d = line_q + 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (scan_idx_q < 5'(NCAND)) begin
          cand_vld_d = 1'b1;
          cand_idx_d = scan_idx_q;
          cand_sad_d = acc_q[scan_idx_q];
          scan_idx_d = scan_idx_q + 5'd1;
        end
        // Strictly-smaller update means ties keep the lower index.
        if (cand_vld_q) begin
          if ((cand_idx_q == 5'd0) || (cand_sad_q < best_sad_q)) begin
            best_idx_d = cand_idx_q;
            best_sad_d = cand_sad_q;
          end
          if (cand_idx_q == 5'(NCAND - 1)) begin
            state_d    = ST_OUT;
            scan_idx_d = '0;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          for (int k = 0; k < NCAND; k++) acc_d[k] = '0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    // flush wins over everything, including a final beat or out_ready
    if (flush) begin
      state_d    = ST_ACCUM;
      line_d     = '0;
      scan_idx_d = '0;
      cand_vld_d = 1'b0;
      for (int k = 0; k < NCAND; k++) acc_d[k] = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      line_q     <= '0;
      scan_idx_q <= '0;
      cand_vld_q <= 1'b0;
      cand_idx_q <= '0;
      cand_sad_q <= '0;
      best_idx_q <= '0;
      best_sad_q <= '0;
      for (int k = 0; k < NCAND; k++) acc_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      scan_idx_q <= scan_idx_d;
      cand_vld_q <= cand_vld_d;
      cand_idx_q <= cand_idx_d;
      cand_sad_q <= cand_sad_d;
      best_idx_q <= best_idx_d;
      best_sad_q <= best_sad_d;
      for (int k = 0; k < NCAND; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: tb/tb_frac_sad_accum.sv
// tb_frac_sad_accum
// Directed bench for frac_sad_accum. Each block's expected winner is pushed
// to a scoreboard queue when the block is driven. It is popped when out_valid
// appears and is then compared together with the result latency and the
// handshake behaviour.
module tb_frac_sad_accum;

  typedef struct {
    logic [4:0]  idx;
    logic [13:0] sad;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1599:0] diff_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    best_idx;
  logic [13:0]   best_sad;

  int            checks = 0;
  int            failures = 0;
  exp_t          sb [$];
  logic [1599:0] rand_beats [8];

  frac_sad_accum #(.LINES(8), .NCAND(25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff_in   (diff_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .best_idx  (best_idx),
    .best_sad  (best_sad)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point used by all checks
  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Beat patterns: 0 cand7=1 others 2; 1 all 0; 2 all FF, cand24 FE; 3 all FF;
  // 4 cand12=3 others 4; 5 random table; 6 filler 0x50
  function automatic logic [1599:0] makeBeat(input int mode, input int line);
    logic [1599:0] v;
    logic [7:0]    val;
    v = '0;
    for (int k = 0; k < 25; k++) begin
      for (int p = 0; p < 8; p++) begin
        case (mode)
          0: val = (k == 7) ? 8'd1 : 8'd2;
          1: val = 8'd0;
          2: val = (k == 24) ? 8'hFE : 8'hFF;
          3: val = 8'hFF;
          4: val = (k == 12) ? 8'd3 : 8'd4;
          5: val = rand_beats[line][64*k + 8*p +: 8];
          default: val = 8'h50;
        endcase
        v[64*k + 8*p +: 8] = val;
      end
    end
    return v;
  endfunction

  // Drive `nbeats` beats of a pattern. When `push` is set, queue the expected
  // winner (constants for directed patterns, an accumulate/argmin model for
  // random ones). Returns #1 after the edge that accepted the last beat.
  task automatic applyStimulus(input int mode, input int nbeats, input bit gaps,
                               input bit push, input int e_idx, input int e_sad);
    int   macc [25];
    exp_t e;
    for (int k = 0; k < 25; k++) macc[k] = 0;
    chk("in_ready_block_start", 32'(in_ready), 32'd1);
    for (int l = 0; l < nbeats; l++) begin
      in_valid = 1'b1;
      diff_in  = makeBeat(mode, l);
      for (int k = 0; k < 25; k++)
        for (int p = 0; p < 8; p++)
          macc[k] += int'(diff_in[64*k + 8*p +: 8]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      diff_in  = makeBeat(6, 0);
      if (gaps && (l != nbeats - 1)) repeat (l % 3) begin
        @(posedge clk); #1;
      end
    end
    if (push) begin
      if (mode == 5) begin
        e.idx = 5'd0;
        e.sad = 14'(macc[0]);
        for (int k = 1; k < 25; k++)
          if (macc[k] < int'(e.sad)) begin
            e.idx = 5'(k);
            e.sad = 14'(macc[k]);
          end
      end else begin
        e.idx = 5'(e_idx);
        e.sad = 14'(e_sad);
      end
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for out_valid, check latency from the last accepted beat,
  // compare against the scoreboard, optionally stall, then consume.
  task automatic checkOutput(input int stall);
    int   n;
    exp_t e;
    n = 0;
    while (n < 40 && out_valid !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_latency", 32'(n), 32'd26);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1) return;
    chk("best_idx", 32'(best_idx), 32'(e.idx));
    chk("best_sad", 32'(best_sad), 32'(e.sad));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", {15'd0, out_valid, in_ready, best_idx, best_sad},
          {15'd0, 1'b1, 1'b0, e.idx, e.sad});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_to_accum", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    int highs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    diff_in   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    for (int l = 0; l < 8; l++)
      for (int j = 0; j < 50; j++)
        rand_beats[l][32*j +: 32] = $urandom;

    // Reset state while held
    #2;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_best", {13'd0, best_idx, best_sad}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Cand 7 cheapest, with a 10-cycle output stall
    applyStimulus(0, 8, 1'b0, 1'b1, 7, 64);
    checkOutput(10);
    // All zero: tie goes to index 0
    applyStimulus(1, 8, 1'b0, 1'b1, 0, 0);
    checkOutput(0);
    // Near-maximum values, last index wins
    applyStimulus(2, 8, 1'b0, 1'b1, 24, 16256);
    checkOutput(0);
    // Maximum value, no wrap
    applyStimulus(3, 8, 1'b0, 1'b1, 0, 16320);
    checkOutput(0);

    // Flush after 5 beats, with a beat presented alongside flush
    applyStimulus(6, 5, 1'b0, 1'b0, 0, 0);
    in_valid = 1'b1;
    diff_in  = makeBeat(3, 0);
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_state", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    applyStimulus(4, 8, 1'b0, 1'b1, 12, 192);
    checkOutput(0);

    // Reset pulse during SCAN discards the pending result
    applyStimulus(3, 8, 1'b0, 1'b0, 0, 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    chk("midscan_reset_ready", {30'd0, in_ready, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) highs++;
    end
    chk("no_result_after_reset", 32'(highs), 32'd0);

    // Random block back-to-back, then the same beats with gaps
    applyStimulus(5, 8, 1'b0, 1'b1, 0, 0);
    checkOutput(0);
    applyStimulus(5, 8, 1'b1, 1'b1, 0, 0);
    checkOutput(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/frac_sad_accum.md
FRAC_SAD_ACCUM -- requirements
Module: frac_sad_accum

Interface
REQ-001 SHALL have parameter LINES, default 8, meaning rows per block accumulated before search.
REQ-002 SHALL have parameter NCAND, default 25, meaning fractional candidates per block (5 vertical x 5 horizontal phases).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  diff line beat present.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready at clk edge.
REQ-007 SHALL have port diff_in  input  1600  25 candidates x 8 pixels x 8-bit unsigned abs diffs; candidate k at [64k+63:64k], pixel p at [64k+8p+7:64k+8p].
REQ-008 SHALL have port flush  input  1  synchronous abort of current block.
REQ-009 SHALL have port out_valid  output  1  best result present.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 SHALL have port best_idx  output  5  winning candidate index, 0..24.
REQ-012 SHALL have port best_sad  output  14  SAD of winning candidate.

Function
REQ-013 SHALL use candidate index k = 5*v + h; v: 0=upper half,1=upper quarter,2=middle,3=lower quarter,4=lower half; h: 0=-1/2,1=-1/4,2=full,3=+1/4,4=+1/2; k=12 is the full-pel position.
REQ-014 SHALL implement FSM states ACCUM, SCAN, OUT; reset state ACCUM.
REQ-015 SHALL drive in_ready=1 only in ACCUM; out_valid=1 only in OUT.
REQ-016 SHALL, per accepted beat, add the 8-pixel sum (11 bits) of each candidate into its 14-bit accumulator; line counter increments 0..LINES-1.
REQ-017 SHALL, on accepting the beat with line counter = LINES-1, reset the counter to 0 and enter SCAN next cycle.
REQ-018 SHALL in SCAN examine one candidate per cycle, index 0..24 ascending, 25 cycles; running minimum updated only on strictly smaller SAD (ties keep lower index); index 0 loads unconditionally.
REQ-019 SHALL enter OUT after index 24 is examined; latency: last beat accepted at edge T -> out_valid high from edge T+26.
REQ-020 SHALL hold best_idx/best_sad stable while out_valid=1 and out_ready=0.
REQ-021 SHALL on out_valid && out_ready clear all accumulators and return to ACCUM next cycle; in_ready rises that cycle.
REQ-022 SHALL treat accumulators as non-saturating; max value 8*8*255=16320 fits 14 bits, no overflow possible with LINES=8.
REQ-023 SHALL on flush=1 in any state clear accumulators, line counter, scan index and go to ACCUM; a beat presented with flush=1 is discarded; flush overrides out_ready and a simultaneous final beat.
REQ-024 SHALL ignore diff_in when in_valid=0 or in_ready=0.
REQ-025 SHALL keep best_idx/best_sad as registered outputs; values outside OUT are don't-care but must be deterministic.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force state ACCUM, line counter 0, scan index 0, all accumulators 0, in_ready=0 while asserted then 1 after release, out_valid=0, best_idx=0, best_sad=0.
REQ-027 SHALL, on reset asserted mid-block or in OUT, discard partial sums and pending result; first beat after release counts as line 0.

Verification
REQ-028 SHALL cover: 8 beats, all diffs 0 except candidate 7 pixels all 1 and others all 2 -> out_valid at T+26, best_idx=7, best_sad=64.
REQ-029 SHALL cover: 8 beats, all candidates all-zero diffs -> best_idx=0, best_sad=0 (tie to lowest index).
REQ-030 SHALL cover: 8 beats all 0xFF except candidate 24 all 0xFE -> best_idx=24, best_sad=16256; all-0xFF case gives best_sad=16320, no wrap.
REQ-031 SHALL cover: out_ready held 0 for 10 cycles -> outputs stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle, next block result independent of previous.
REQ-032 SHALL cover: flush after 5 beats, then 8 fresh beats with candidate 12 minimal (all 3, others 4) -> best_idx=12, best_sad=192.
REQ-033 SHALL cover: rst_n pulsed low during SCAN -> out_valid stays 0, next 8 beats produce correct result; in_valid toggling with gaps yields identical result to back-to-back beats.
